aes_round_ctrl: RTL

Sequencer for the AES round datapath. It accepts a host start request, runs key expansion when required, then drives the round function's `set`, `round`, `done`, `keygen`, `enc` and `mode` inputs through one full AES-128/192/256 encryption. It reports completion to the host with a one-cycle `out_valid` pulse. It sits between the host interface and the round function / key-expansion pair.

---
 rtl/aes_round_ctrl_if.sv | 29 ++
 rtl/aes_round_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl_if.sv
// Host / round-datapath handshake bundle for the AES round sequencer.
// The slave view belongs to the controller, and the master view to whatever drives it.
interface aes_round_ctrl_if;
    logic       start;
    logic       new_key;
    logic [1:0] mode_in;
    logic       abort;
    logic       key_done;
    logic       ready;
    logic       key_start;
    logic       keygen;
    logic       enc;
    logic       set;
    logic [4:0] round;
    logic       done;
    logic [1:0] mode;
    logic       out_valid;
    logic       err;

    modport slave (
        input  start, new_key, mode_in, abort, key_done,
        output ready, key_start, keygen, enc, set, round, done, mode, out_valid, err
    );

    modport master (
        output start, new_key, mode_in, abort, key_done,
        input  ready, key_start, keygen, enc, set, round, done, mode, out_valid, err
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128/192/256 round sequencer. It runs key expansion only when the cached key is unusable,
// then steps the round index from 2 up to Nr+2.
module aes_round_ctrl (
    input  logic            clk,
    input  logic            rst_n,
    aes_round_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_KEYGEN    = 2'd1;
    localparam logic [1:0] S_LOAD      = 2'd2;
    localparam logic [1:0] S_ROUND     = 2'd3;
    localparam logic [1:0] MODE_RSVD   = 2'b11;
    localparam logic [4:0] ROUND_FIRST = 5'd2;
    localparam logic [4:0] ROUND_BASE  = 5'd12;

    logic [1:0] r_state;
    logic [1:0] r_mode;
    logic [1:0] r_key_mode;
    logic [4:0] r_round;
    logic       r_enc;
    logic       r_key_ok;
    logic       r_key_start;
    logic       r_out_valid;
    logic       r_err;

    logic       w_idle;
    logic       w_accept;
    logic       w_reject;
    logic       w_need_key;
    logic       w_last;
    logic [4:0] w_last_round;

    always_comb begin
        w_idle       = (r_state == S_IDLE);
        w_accept     = w_idle && bus.start && (bus.mode_in != MODE_RSVD);
        w_reject     = w_idle && bus.start && (bus.mode_in == MODE_RSVD);
        w_need_key   = bus.new_key || !r_key_ok || (bus.mode_in != r_key_mode);
        // Final round index Nr+2 equals 12 + 2*mode for the three legal modes.
        w_last_round = ROUND_BASE + {2'b00, r_mode, 1'b0};
        w_last       = (r_state == S_ROUND) && (r_round == w_last_round);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_key_mode  <= '0;
            r_round     <= '0;
            r_enc       <= 1'b0;
            r_key_ok    <= 1'b0;
            r_key_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_key_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_reject) begin
                        r_err <= 1'b1;
                    end else if (w_accept) begin
                        r_mode <= bus.mode_in;
                        if (w_need_key) begin
                            r_state     <= S_KEYGEN;
                            r_key_start <= 1'b1;
                            r_enc       <= 1'b0;
                        end else begin
                            r_state <= S_LOAD;
                            r_round <= ROUND_FIRST;
                            r_enc   <= 1'b1;
                        end
                    end
                end
                S_KEYGEN: begin
                    // Abort takes priority over a coincident key_done and discards the key.
                    if (bus.abort) begin
                        r_state  <= S_IDLE;
                        r_round  <= '0;
                        r_key_ok <= 1'b0;
                    end else if (bus.key_done) begin
                        r_key_ok   <= 1'b1;
                        r_key_mode <= r_mode;
                        r_state    <= S_LOAD;
                        r_round    <= ROUND_FIRST;
                        r_enc      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_round <= '0;
                    end else begin
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_round <= '0;
                    end else if (w_last) begin
                        r_state     <= S_IDLE;
                        r_round     <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_round <= r_round + 5'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_round <= '0;
                end
            endcase
        end
    end

    assign bus.ready     = w_idle;
    assign bus.key_start = r_key_start;
    assign bus.keygen    = (r_state == S_KEYGEN);
    assign bus.enc       = r_enc;
    assign bus.set       = (r_state == S_LOAD);
    assign bus.round     = r_round;
    assign bus.done      = w_last;
    assign bus.mode      = r_mode;
    assign bus.out_valid = r_out_valid;
    assign bus.err       = r_err;
endmodule
